rf_write_arbiter: RTL and testbench

- Shares the single register-file write port among three sources:
  - the pipeline writeback stage (weregfile/datatoregfile path);
  - the multi-cycle unit (divider/multiplier results);
  - the debug loader.
- Pipeline writeback has priority. Multi-cycle results are buffered in a small FIFO and drained into idle write-port slots.
- A starvation counter requests a pipeline bubble when a buffered result waits too long.
- Sits between the wb stage and the register file; stall_req goes to the hazard unit.

---
 rtl/rf_write_arbiter.sv | 140 ++++++++++++++
 tb/tb_rf_write_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rf_write_arbiter
// Purpose  : Shares the register-file write port among pipeline writeback,
//            buffered multi-cycle results and the debug loader.
// Revision : 1.0 - initial release
// ============================================================================
module rf_write_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int FIFO_DEPTH = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wb_we,
  input  logic [ADDR_W-1:0]           wb_addr,
  input  logic [DATA_W-1:0]           wb_data,
  input  logic                        mc_valid,
  output logic                        mc_ready,
  input  logic [ADDR_W-1:0]           mc_addr,
  input  logic [DATA_W-1:0]           mc_data,
  input  logic                        dbg_valid,
  output logic                        dbg_ready,
  input  logic [ADDR_W-1:0]           dbg_addr,
  input  logic [DATA_W-1:0]           dbg_data,
  output logic                        rf_we,
  output logic [ADDR_W-1:0]           rf_waddr,
  output logic [DATA_W-1:0]           rf_wdata,
  output logic                        stall_req,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int IDX_W = $clog2(FIFO_DEPTH);
  localparam int STV_W = $clog2(STARVE_MAX + 1);
  localparam logic [STV_W-1:0] STV_MAX = STV_W'(STARVE_MAX);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  logic [ADDR_W-1:0] addr_q [FIFO_DEPTH];
  logic [ADDR_W-1:0] addr_d [FIFO_DEPTH];
  logic [DATA_W-1:0] data_q [FIFO_DEPTH];
  logic [DATA_W-1:0] data_d [FIFO_DEPTH];
  logic [CNT_W-1:0]  count_q, count_d;
  logic [STV_W-1:0]  starve_q, starve_d;
  logic              stall_q, stall_d;
  logic              rf_we_q;
  logic [ADDR_W-1:0] rf_waddr_q;
  logic [DATA_W-1:0] rf_wdata_q;

  logic              fifo_ne, grant_fifo, grant_dbg, enq, kill_en, wr_issue;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  assign fifo_ne    = (count_q != '0);
  assign grant_fifo = !wb_we && fifo_ne;
  assign grant_dbg  = !wb_we && !fifo_ne && dbg_valid;
  assign mc_ready   = rst && (count_q < CNT_FULL);
  assign dbg_ready  = rst && grant_dbg;
  assign enq        = mc_valid && mc_ready;
  assign kill_en    = wb_we && (wb_addr != '0);

  // Survivors are packed toward slot 0 so the head is always a live entry;
  // the incoming entry is appended after the kill filter, so it survives.
  always_comb begin
    addr_d  = addr_q;
    data_d  = data_q;
    count_d = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if ((CNT_W'(i) < count_q) && !(grant_fifo && (i == 0)) &&
          !(kill_en && (addr_q[i] == wb_addr))) begin
        addr_d[count_d[IDX_W-1:0]] = addr_q[i];
        data_d[count_d[IDX_W-1:0]] = data_q[i];
        count_d = count_d + CNT_W'(1);
      end
    end
    if (enq) begin
      addr_d[count_d[IDX_W-1:0]] = mc_addr;
      data_d[count_d[IDX_W-1:0]] = mc_data;
      count_d = count_d + CNT_W'(1);
    end
  end

  always_comb begin
    sel_addr = dbg_addr;
    sel_data = dbg_data;
    if (wb_we) begin
      sel_addr = wb_addr;
      sel_data = wb_data;
    end else if (fifo_ne) begin
      sel_addr = addr_q[0];
      sel_data = data_q[0];
    end
  end

  assign wr_issue = (wb_we || fifo_ne || dbg_valid) && (sel_addr != '0);

  always_comb begin
    starve_d = '0;
    if (fifo_ne && !grant_fifo) begin
      starve_d = (starve_q == STV_MAX) ? starve_q : starve_q + STV_W'(1);
    end
  end

  // An empty FIFO also drops the bubble request so a kill cannot leave it stuck.
  assign stall_d = (grant_fifo || !fifo_ne) ? 1'b0 : (stall_q || (starve_q == STV_MAX));

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q    <= '0;
      starve_q   <= '0;
      stall_q    <= 1'b0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      count_q  <= count_d;
      starve_q <= starve_d;
      stall_q  <= stall_d;
      rf_we_q  <= wr_issue;
      if (wr_issue) begin
        rf_waddr_q <= sel_addr;
        rf_wdata_q <= sel_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    data_q <= data_d;
  end

  assign rf_we      = rf_we_q;
  assign rf_waddr   = rf_waddr_q;
  assign rf_wdata   = rf_wdata_q;
  assign stall_req  = stall_q;
  assign fifo_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_rf_write_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// Self-checking bench for rf_write_arbiter: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_rf_write_arbiter;
  localparam int DW = 32, AW = 5, DEPTH = 2, SMAX = 4;
  localparam int CW = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          wb_we, mc_valid, dbg_valid;
  logic [AW-1:0] wb_addr, mc_addr, dbg_addr;
  logic [DW-1:0] wb_data, mc_data, dbg_data;
  logic          mc_ready, dbg_ready, rf_we, stall_req;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic [CW-1:0] fifo_count;

  always #5 clk = ~clk;

  rf_write_arbiter #(.DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .mc_valid(mc_valid), .mc_ready(mc_ready), .mc_addr(mc_addr), .mc_data(mc_data),
    .dbg_valid(dbg_valid), .dbg_ready(dbg_ready), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .stall_req(stall_req), .fifo_count(fifo_count)
  );

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  ent_t          m_q[$];
  int            m_cnt;
  bit            m_stall, m_we, m_mc_ready, m_dbg_ready;
  logic [AW-1:0] m_waddr;
  logic [DW-1:0] m_wdata;
  int            checks = 0;
  int            errors = 0;

  task automatic model_comb();
    m_mc_ready  = rst && (m_q.size() < DEPTH);
    m_dbg_ready = rst && !wb_we && (m_q.size() == 0) && dbg_valid;
  endtask

  // Advance the reference model with the current inputs, then cross the edge.
  task automatic tick();
    ent_t          keep[$];
    ent_t          e;
    bit            gff, gany, enq;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    model_comb();
    if (!rst) begin
      m_q.delete();
      m_cnt = 0; m_stall = 0; m_we = 0; m_waddr = '0; m_wdata = '0;
    end else begin
      gff  = !wb_we && (m_q.size() != 0);
      enq  = mc_valid && m_mc_ready;
      gany = 1;
      wa   = '0;
      wd   = '0;
      if (wb_we) begin wa = wb_addr; wd = wb_data; end
      else if (gff) begin wa = m_q[0].a; wd = m_q[0].d; end
      else if (dbg_valid) begin wa = dbg_addr; wd = dbg_data; end
      else gany = 0;
      m_we = gany && (wa != 0);
      if (m_we) begin m_waddr = wa; m_wdata = wd; end
      m_stall = (gff || m_q.size() == 0) ? 1'b0 : (m_stall || m_cnt == SMAX);
      m_cnt   = (m_q.size() != 0 && !gff) ? ((m_cnt < SMAX) ? m_cnt + 1 : SMAX) : 0;
      if (gff) void'(m_q.pop_front());
      foreach (m_q[i])
        if (!(wb_we && wb_addr != 0 && m_q[i].a == wb_addr)) keep.push_back(m_q[i]);
      if (enq) begin e.a = mc_addr; e.d = mc_data; keep.push_back(e); end
      m_q = keep;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wb_we = 0; wb_addr = '0; wb_data = '0;
    mc_valid = 0; mc_addr = '0; mc_data = '0;
    dbg_valid = 0; dbg_addr = '0; dbg_data = '0;
  endtask

  task automatic test_reset();
    idle();
    rst = 0;
    dbg_valid = 1; dbg_addr = 5'd3; mc_valid = 1; mc_addr = 5'd2;
    tick();
    #1;
    checks++; if (mc_ready !== 1'b0) begin errors++; $display("FAIL reset_mc_ready got %b want 0", mc_ready); end
    checks++; if (dbg_ready !== 1'b0) begin errors++; $display("FAIL reset_dbg_ready got %b want 0", dbg_ready); end
    checks++;
    if ({rf_we, rf_waddr, rf_wdata, stall_req, fifo_count} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got we=%b a=%0d d=%h st=%b cnt=%0d want all 0",
               rf_we, rf_waddr, rf_wdata, stall_req, fifo_count);
    end
    idle();
    tick();
    rst = 1;
    repeat (4) tick();
  endtask

  task automatic test_wb_write();
    wb_we = 1; wb_addr = 5'd3; wb_data = 32'hDEADBEEF;
    tick();
    checks++;
    if ({rf_we, rf_waddr, rf_wdata, stall_req} !== {1'b1, 5'd3, 32'hDEADBEEF, 1'b0}) begin
      errors++;
      $display("FAIL wb_write got we=%b a=%0d d=%h st=%b want we=1 a=3 d=deadbeef st=0",
               rf_we, rf_waddr, rf_wdata, stall_req);
    end
    idle();
    tick();
    checks++;
    if ({rf_we, rf_waddr, rf_wdata, stall_req} !== {1'b0, 5'd3, 32'hDEADBEEF, 1'b0}) begin
      errors++;
      $display("FAIL wb_hold got we=%b a=%0d d=%h st=%b want we=0 a=3 d=deadbeef st=0",
               rf_we, rf_waddr, rf_wdata, stall_req);
    end
  endtask

  task automatic test_mc_path();
    mc_valid = 1; mc_addr = 5'd7; mc_data = 32'h12345678;
    #1;
    checks++; if (mc_ready !== 1'b1) begin errors++; $display("FAIL mc_ready_empty got %b want 1", mc_ready); end
    tick();
    mc_valid = 0;
    checks++;
    if ({fifo_count, rf_we} !== {CW'(1), 1'b0}) begin
      errors++; $display("FAIL mc_n1 got cnt=%0d we=%b want cnt=1 we=0", fifo_count, rf_we);
    end
    tick();
    checks++;
    if ({fifo_count, rf_we, rf_waddr, rf_wdata} !== {CW'(0), 1'b1, 5'd7, 32'h12345678}) begin
      errors++;
      $display("FAIL mc_n2 got cnt=%0d we=%b a=%0d d=%h want cnt=0 we=1 a=7 d=12345678",
               fifo_count, rf_we, rf_waddr, rf_wdata);
    end
    tick();
  endtask

  task automatic test_fill_starve();
    wb_we = 1; wb_addr = 5'd1; wb_data = 32'h0000_1111;
    mc_valid = 1; mc_addr = 5'd10; mc_data = 32'hAAAA_0010;
    tick();
    mc_addr = 5'd11; mc_data = 32'hAAAA_0011;
    #1;
    checks++; if (mc_ready !== 1'b1) begin errors++; $display("FAIL fill_ready1 got %b want 1", mc_ready); end
    tick();
    mc_valid = 0;
    #1;
    checks++;
    if ({mc_ready, fifo_count} !== {1'b0, CW'(2)}) begin
      errors++; $display("FAIL fill_full got ready=%b cnt=%0d want ready=0 cnt=2", mc_ready, fifo_count);
    end
    repeat (3) tick();
    checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL starve_early got %b want 0", stall_req); end
    tick();
    checks++; if (stall_req !== 1'b1) begin errors++; $display("FAIL starve_set got %b want 1", stall_req); end
    wb_we = 0;
    tick();
    checks++;
    if ({rf_we, rf_waddr, rf_wdata, stall_req} !== {1'b1, 5'd10, 32'hAAAA_0010, 1'b0}) begin
      errors++;
      $display("FAIL drain1 got we=%b a=%0d d=%h st=%b want we=1 a=10 d=aaaa0010 st=0",
               rf_we, rf_waddr, rf_wdata, stall_req);
    end
    tick();
    checks++;
    if ({rf_we, rf_waddr, rf_wdata, fifo_count} !== {1'b1, 5'd11, 32'hAAAA_0011, CW'(0)}) begin
      errors++;
      $display("FAIL drain2 got we=%b a=%0d d=%h cnt=%0d want we=1 a=11 d=aaaa0011 cnt=0",
               rf_we, rf_waddr, rf_wdata, fifo_count);
    end
    tick();
  endtask

  task automatic test_kill();
    mc_valid = 1; mc_addr = 5'd9; mc_data = 32'h0000_0A0A;
    tick();
    mc_valid = 0;
    wb_we = 1; wb_addr = 5'd9; wb_data = 32'h0000_0B0B;
    tick();
    checks++;
    if ({fifo_count, rf_we, rf_waddr, rf_wdata} !== {CW'(0), 1'b1, 5'd9, 32'h0000_0B0B}) begin
      errors++;
      $display("FAIL kill got cnt=%0d we=%b a=%0d d=%h want cnt=0 we=1 a=9 d=00000b0b",
               fifo_count, rf_we, rf_waddr, rf_wdata);
    end
    idle();
    tick();
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL kill_nowrite got we=%b want 0", rf_we); end
    // Same-cycle enqueue and kill: the newer incoming entry must survive.
    mc_valid = 1; mc_addr = 5'd9; mc_data = 32'h0000_0A0A;
    tick();
    wb_we = 1; wb_addr = 5'd9; wb_data = 32'h0000_0B0B;
    mc_data = 32'h0000_0C0C;
    tick();
    idle();
    checks++; if (fifo_count !== CW'(1)) begin errors++; $display("FAIL kill_keep_new got cnt=%0d want 1", fifo_count); end
    tick();
    checks++;
    if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd9, 32'h0000_0C0C}) begin
      errors++;
      $display("FAIL kill_new_write got we=%b a=%0d d=%h want we=1 a=9 d=00000c0c", rf_we, rf_waddr, rf_wdata);
    end
    tick();
  endtask

  task automatic test_reg0_dbg();
    wb_we = 1; wb_addr = 5'd0; wb_data = 32'hFFFF_FFFF;
    tick();
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reg0_wb got we=%b want 0", rf_we); end
    mc_valid = 1; mc_addr = 5'd4; mc_data = 32'h4444_4444;
    tick();
    mc_addr = 5'd5; mc_data = 32'h5555_5555;
    tick();
    checks++; if (fifo_count !== CW'(2)) begin errors++; $display("FAIL reg0_nokill got cnt=%0d want 2", fifo_count); end
    idle();
    dbg_valid = 1; dbg_addr = 5'd6; dbg_data = 32'h6666_6666;
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++; if (dbg_ready !== 1'b0) begin errors++; $display("FAIL dbg_blocked%0d got %b want 0", k, dbg_ready); end
      tick();
    end
    #1;
    checks++; if (dbg_ready !== 1'b1) begin errors++; $display("FAIL dbg_grant got %b want 1", dbg_ready); end
    tick();
    dbg_valid = 0;
    checks++;
    if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd6, 32'h6666_6666}) begin
      errors++;
      $display("FAIL dbg_write got we=%b a=%0d d=%h want we=1 a=6 d=66666666", rf_we, rf_waddr, rf_wdata);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    wb_we = 1; wb_addr = 5'd2; wb_data = 32'h2222_2222;
    mc_valid = 1; mc_addr = 5'd12; mc_data = 32'hC0C0_0012;
    tick();
    mc_addr = 5'd13; mc_data = 32'hC0C0_0013;
    tick();
    mc_valid = 0;
    repeat (4) tick();
    checks++;
    if ({stall_req, fifo_count} !== {1'b1, CW'(2)}) begin
      errors++; $display("FAIL pre_reset got st=%b cnt=%0d want st=1 cnt=2", stall_req, fifo_count);
    end
    rst = 0; wb_we = 0; mc_valid = 1;
    #1;
    checks++; if (mc_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_ready got %b want 0", mc_ready); end
    tick();
    checks++;
    if ({rf_we, rf_waddr, rf_wdata, stall_req, fifo_count} !== '0) begin
      errors++;
      $display("FAIL mid_reset got we=%b a=%0d d=%h st=%b cnt=%0d want all 0",
               rf_we, rf_waddr, rf_wdata, stall_req, fifo_count);
    end
    rst = 1; mc_valid = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if ({rf_we, fifo_count} !== {1'b0, CW'(0)}) begin
        errors++; $display("FAIL post_reset%0d got we=%b cnt=%0d want 0 0", k, rf_we, fifo_count);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      rst       = ($urandom_range(0, 79) != 0);
      wb_we     = ($urandom_range(0, 2) == 0);
      wb_addr   = AW'($urandom_range(0, 3));
      wb_data   = $urandom;
      mc_valid  = ($urandom_range(0, 1) == 1);
      mc_addr   = AW'($urandom_range(0, 3));
      mc_data   = $urandom;
      dbg_valid = ($urandom_range(0, 2) == 0);
      dbg_addr  = AW'($urandom_range(0, 7));
      dbg_data  = $urandom;
      #1;
      model_comb();
      checks++;
      if ({mc_ready, dbg_ready} !== {m_mc_ready, m_dbg_ready}) begin
        errors++;
        $display("FAIL rand_ready c=%0d got mc=%b dbg=%b want mc=%b dbg=%b",
                 c, mc_ready, dbg_ready, m_mc_ready, m_dbg_ready);
      end
      tick();
      checks++;
      if ({rf_we, rf_waddr, rf_wdata, stall_req, fifo_count} !==
          {m_we, m_waddr, m_wdata, m_stall, CW'(m_q.size())}) begin
        errors++;
        $display("FAIL rand_out c=%0d got we=%b a=%0d d=%h st=%b cnt=%0d want we=%b a=%0d d=%h st=%b cnt=%0d",
                 c, rf_we, rf_waddr, rf_wdata, stall_req, fifo_count,
                 m_we, m_waddr, m_wdata, m_stall, m_q.size());
      end
    end
  endtask

  initial begin
    test_reset();
    test_wb_write();
    test_mc_path();
    test_fill_starve();
    test_kill();
    test_reg0_dbg();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
